// File: rtl/input_conditioner_pkg.sv
// Shared defaults and counter sizing for the input conditioner bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package input_conditioner_pkg;

    localparam int DEF_N    = 5;
    localparam int DEF_WAIT = 3;

    // One extra bit over clog2 so a counter reaching WAIT-1 can never wrap.
    function automatic int cnt_width(input int wait_cycles);
        return $clog2(wait_cycles) + 1;
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One channel: 2-flop synchronizer, stability counter, debounced level, edge pulses.
// Latency: WAIT+1 edges from a stable input change to conditioned/pulse.
// Backpressure: none; free-running, pulses last exactly one cycle.
module input_conditioner_ch
    import input_conditioner_pkg::*;
#(
    parameter int WAIT = DEF_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy_in,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    localparam int             CW       = cnt_width(WAIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cond_q, cond_d;
    logic          pos_q, pos_d;
    logic          neg_q, neg_d;

    always_comb begin
        s1_d   = noisy_in;
        s2_d   = s1_q;
        cnt_d  = '0;
        cond_d = cond_q;
        pos_d  = 1'b0;
        neg_d  = 1'b0;
        // Any cycle where s2 matches the accepted level restarts qualification.
        if (s2_q != cond_q) begin
            if (cnt_q == CNT_LAST) begin
                cond_d = s2_q;
                pos_d  = s2_q;
                neg_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            cond_q <= 1'b0;
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cnt_q  <= cnt_d;
            cond_q <= cond_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
        end
    end

    assign conditioned  = cond_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;

endmodule

// File: rtl/input_conditioner_bank.sv
// Bank of N independent debounced inputs with registered edge pulses.
// Latency: WAIT+1 edges per channel from stable input change to output.
// Backpressure: none; each channel is free-running.
module input_conditioner_bank
    import input_conditioner_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int WAIT = DEF_WAIT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] noisyin,
    output logic [N-1:0] conditioned,
    output logic [N-1:0] positiveedge,
    output logic [N-1:0] negativeedge
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        input_conditioner_ch #(
            .WAIT (WAIT)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .noisy_in     (noisyin[i]),
            .conditioned  (conditioned[i]),
            .positiveedge (positiveedge[i]),
            .negativeedge (negativeedge[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Bench for input_conditioner_bank: WAIT=3 and WAIT=1 instances against a window-based model.
module tb_input_conditioner_bank;

    localparam int N  = 5;
    localparam int W0 = 3;
    localparam int W1 = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] noisyin = '0;
    logic [N-1:0] c0, p0, n0, c1, p1, n1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    input_conditioner_bank #(.N(N), .WAIT(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .noisyin(noisyin),
        .conditioned(c0), .positiveedge(p0), .negativeedge(n0)
    );

    input_conditioner_bank #(.N(N), .WAIT(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .noisyin(noisyin),
        .conditioned(c1), .positiveedge(p1), .negativeedge(n1)
    );

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a synchronized sample reaches the decision point two edges after
    // capture; a channel accepts when the last W decision samples all differ
    // from its accepted level.
    logic [N-1:0] samp_q[$];
    logic [N-1:0] s2hist[$];
    logic [N-1:0] m_cond[2];
    logic [N-1:0] m_pos[2];
    logic [N-1:0] m_neg[2];
    logic [N-1:0] mdl_s2;
    logic [N-1:0] mdl_h;
    int           mdl_w;
    bit           mdl_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q.delete();
            s2hist.delete();
            for (int d = 0; d < 2; d++) begin
                m_cond[d] = '0;
                m_pos[d]  = '0;
                m_neg[d]  = '0;
            end
        end else begin
            mdl_s2 = (samp_q.size() >= 2) ? samp_q[samp_q.size() - 2] : '0;
            s2hist.push_back(mdl_s2);
            for (int d = 0; d < 2; d++) begin
                mdl_w = (d == 0) ? W0 : W1;
                for (int i = 0; i < N; i++) begin
                    mdl_ok = (s2hist.size() >= mdl_w);
                    for (int j = 0; j < mdl_w; j++) begin
                        if (mdl_ok) begin
                            mdl_h = s2hist[s2hist.size() - 1 - j];
                            if (mdl_h[i] == m_cond[d][i]) mdl_ok = 1'b0;
                        end
                    end
                    if (mdl_ok) begin
                        m_cond[d][i] = mdl_s2[i];
                        m_pos[d][i]  = mdl_s2[i];
                        m_neg[d][i]  = ~mdl_s2[i];
                    end else begin
                        m_pos[d][i]  = 1'b0;
                        m_neg[d][i]  = 1'b0;
                    end
                end
            end
            samp_q.push_back(noisyin);
            if (samp_q.size() > 8) void'(samp_q.pop_front());
            if (s2hist.size() > 8) void'(s2hist.pop_front());
        end
    end

    always @(negedge clk) begin
        check("w3_cond", c0, m_cond[0]);
        check("w3_pos",  p0, m_pos[0]);
        check("w3_neg",  n0, m_neg[0]);
        check("w1_cond", c1, m_cond[1]);
        check("w1_pos",  p1, m_pos[1]);
        check("w1_neg",  n1, m_neg[1]);
        check("w3_excl", p0 & n0, '0);
        check("w1_excl", p1 & n1, '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_cond", c0, '0);
        check("rst_pos",  p0, '0);
        check("rst_neg",  n0, '0);
        rst_n = 1'b1;

        // Change before edge 10 becomes visible after edge 14 (WAIT=3), edge 12 (WAIT=1).
        repeat (9) tick();
        noisyin[0] = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            check("single_pos",  p0, (t == 5) ? 5'b00001 : 5'b00000);
            check("single_cond", c0, (t >= 5) ? 5'b00001 : 5'b00000);
            check("single_neg",  n0, 5'b00000);
            check("w1_single_pos", p1, (t == 3) ? 5'b00001 : 5'b00000);
        end

        // Two-cycle glitch on channel 1 is filtered at WAIT=3.
        noisyin[1] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            if (t == 3) noisyin[1] = 1'b0;
            tick();
            check("glitch_cond", c0 & 5'b00010, 5'b00000);
            check("glitch_pulse", (p0 | n0) & 5'b00010, 5'b00000);
        end

        // Bounce channel 2 then hold high: one pulse WAIT+1 edges after last transition.
        for (int b = 0; b < 4; b++) begin
            noisyin[2] = (b % 2 == 0);
            tick();
            check("bounce_quiet", p0 & 5'b00100, 5'b00000);
        end
        noisyin[2] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check("bounce_pos", p0 & 5'b00100, (t == 5) ? 5'b00100 : 5'b00000);
        end

        // Channel 3 falling edge.
        noisyin[3] = 1'b1;
        repeat (8) tick();
        noisyin[3] = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("fall_neg",  n0 & 5'b01000, (t == 5) ? 5'b01000 : 5'b00000);
            check("fall_pos",  p0 & 5'b01000, 5'b00000);
            check("fall_cond", c0 & 5'b01000, (t < 5) ? 5'b01000 : 5'b00000);
        end

        // Simultaneous rising changes on several channels.
        noisyin = 5'b00000;
        repeat (8) tick();
        noisyin = 5'b10101;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("multi_pos",  p0, (t == 5) ? 5'b10101 : 5'b00000);
            check("multi_cond", c0, (t >= 5) ? 5'b10101 : 5'b00000);
            check("multi_neg",  n0, 5'b00000);
        end

        // Reset mid-count: outputs clear at once, channels re-qualify from zero.
        noisyin = 5'b01111;
        repeat (8) tick();
        check("pre_rst_cond", c0, 5'b01111);
        noisyin = 5'b11111;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("async_cond", c0, 5'b00000);
        check("async_pos",  p0, 5'b00000);
        check("async_neg",  n0, 5'b00000);
        check("async_w1_cond", c1, 5'b00000);
        tick();
        rst_n = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            check("rerun_pos",  p0, (t == 5) ? 5'b11111 : 5'b00000);
            check("rerun_cond", c0, (t >= 5) ? 5'b11111 : 5'b00000);
            check("rerun_w1_pos", p1, (t == 3) ? 5'b11111 : 5'b00000);
        end

        // Random bouncing with occasional resets; the per-cycle comparator checks everything.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_async", c0 | p0 | n0 | c1 | p1 | n1, 5'b00000);
                tick();
                rst_n = 1'b1;
            end else begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 7) == 0) noisyin[i] = ~noisyin[i];
            end
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
